// File: rtl/io_port_unit_if.sv
// io_port_unit_if -- bus bundle between the control unit / external world
// and io_port_unit.
//   master : drives strobes, outgoing register value, external input word
//            and output acknowledge; observes FIFO head, handshake and status.
//   slave  : the io_port_unit side (mirror of master).
// Parameter DW sets the width of every data signal.
interface io_port_unit_if #(
  parameter int DW = 16
);
  logic          InRead;
  logic          OutputWrite;
  logic [DW-1:0] OutData;
  logic [DW-1:0] InData;
  logic [DW-1:0] ExtInData;
  logic          ExtInValid;
  logic          ExtInReady;
  logic [DW-1:0] ExtOutData;
  logic          ExtOutValid;
  logic          ExtOutAck;
  logic          InEmpty;
  logic          OutBusy;
  logic          InUnderflow;
  logic          OutOverflow;

  modport master (
    output InRead, OutputWrite, OutData, ExtInData, ExtInValid, ExtOutAck,
    input  InData, ExtInReady, ExtOutData, ExtOutValid, InEmpty, OutBusy,
           InUnderflow, OutOverflow
  );

  modport slave (
    input  InRead, OutputWrite, OutData, ExtInData, ExtInValid, ExtOutAck,
    output InData, ExtInReady, ExtOutData, ExtOutValid, InEmpty, OutBusy,
           InUnderflow, OutOverflow
  );
endinterface

// File: rtl/io_port_unit.sv
// io_port_unit -- processor I/O port.
// Input side: DEPTH-entry FIFO filled from the external producer
// (ExtInData/ExtInValid/ExtInReady) and popped by the InRead strobe; the
// head is offered combinationally on InData for the write-back mux.
// Output side: one-word holding register with a two-state FSM, loaded by
// the OutputWrite strobe and released by ExtOutAck.
// Ports:
//   CLK    : clock, all state on its rising edge
//   Reset  : synchronous, active-high; clears control state, pending words
//            and sticky flags (FIFO storage itself is left as-is)
//   bus    : io_port_unit_if slave modport carrying all data/handshake/status
module io_port_unit #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  io_port_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic {OUT_IDLE, OUT_VALID} outState_t;

  // ---------------- input FIFO ----------------
  logic [DW-1:0] fifoMem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          inUnderflow;
  logic          push;
  logic          pop;
  logic          notEmpty;

  assign notEmpty = (count != '0);
  // Ready comes from registered count only, so a same-cycle pop never
  // opens a slot combinationally.
  assign push     = bus.ExtInValid & (count < FULL_COUNT);
  assign pop      = bus.InRead & notEmpty;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      inUnderflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      if (bus.InRead && !notEmpty) inUnderflow <= 1'b1;
    end
  end

  // Storage is data only: no reset, write suppressed while Reset is high.
  always_ff @(posedge CLK) begin
    if (push && !Reset) fifoMem[wrPtr] <= bus.ExtInData;
  end

  assign bus.InData      = notEmpty ? fifoMem[rdPtr] : '0;
  assign bus.InEmpty     = ~notEmpty;
  assign bus.ExtInReady  = (count < FULL_COUNT);
  assign bus.InUnderflow = inUnderflow;

  // ---------------- output holding register ----------------
  outState_t     outState;
  outState_t     outStateNext;
  logic          loadOut;
  logic          overflowSet;
  logic [DW-1:0] extOutData;
  logic          outOverflow;

  always_comb begin
    outStateNext = outState;
    loadOut      = 1'b0;
    overflowSet  = 1'b0;
    case (outState)
      OUT_IDLE: begin
        if (bus.OutputWrite) begin
          loadOut      = 1'b1;
          outStateNext = OUT_VALID;
        end
      end
      OUT_VALID: begin
        if (bus.ExtOutAck && bus.OutputWrite) begin
          // Consumer takes the old word as the new one arrives: hand over.
          loadOut = 1'b1;
        end else if (bus.ExtOutAck) begin
          outStateNext = OUT_IDLE;
        end else if (bus.OutputWrite) begin
          overflowSet = 1'b1;
        end
      end
      default: outStateNext = OUT_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      outState    <= OUT_IDLE;
      extOutData  <= '0;
      outOverflow <= 1'b0;
    end else begin
      outState <= outStateNext;
      if (loadOut)     extOutData  <= bus.OutData;
      if (overflowSet) outOverflow <= 1'b1;
    end
  end

  assign bus.ExtOutData  = extOutData;
  assign bus.ExtOutValid = (outState == OUT_VALID);
  assign bus.OutBusy     = (outState == OUT_VALID);
  assign bus.OutOverflow = outOverflow;

endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit -- self-checking bench for io_port_unit (DW=16, DEPTH=4).
// A queue-based reference model tracks the input FIFO contents, the pending
// output word and both sticky flags; every cycle all DUT outputs are
// compared against it. Directed sequences cover the documented scenarios,
// followed by randomized traffic with occasional resets.
module tb_io_port_unit;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic CLK;
  logic Reset;

  io_port_unit_if #(.DW(DW)) bus ();

  io_port_unit #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int vecCount = 0;
  int errCount = 0;

  // reference model state
  logic [DW-1:0] mQ[$];
  bit            mOutValid;
  logic [DW-1:0] mOutWord;
  bit            mUnder;
  bit            mOver;
  bit            modelKnown = 0;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [DW-1:0] expHead;
    expHead = (mQ.size() > 0) ? mQ[0] : '0;
    checkVal("InData",      32'(bus.InData),      32'(expHead));
    checkVal("InEmpty",     32'(bus.InEmpty),     32'(mQ.size() == 0));
    checkVal("ExtInReady",  32'(bus.ExtInReady),  32'(mQ.size() < DEPTH));
    checkVal("ExtOutValid", 32'(bus.ExtOutValid), 32'(mOutValid));
    checkVal("OutBusy",     32'(bus.OutBusy),     32'(mOutValid));
    checkVal("ExtOutData",  32'(bus.ExtOutData),  32'(mOutWord));
    checkVal("InUnderflow", 32'(bus.InUnderflow), 32'(mUnder));
    checkVal("OutOverflow", 32'(bus.OutOverflow), 32'(mOver));
  endtask

  // One clock cycle: drive inputs (called just after a falling edge),
  // check current outputs against the model, advance model over the edge.
  task automatic cycle(input bit rst, input bit inRd, input bit outWr,
                       input logic [DW-1:0] outD, input bit extV,
                       input logic [DW-1:0] extD, input bit ack);
    bit canPush;
    Reset           = rst;
    bus.InRead      = inRd;
    bus.OutputWrite = outWr;
    bus.OutData     = outD;
    bus.ExtInValid  = extV;
    bus.ExtInData   = extD;
    bus.ExtOutAck   = ack;
    #1;
    if (modelKnown) checkAll();
    if (rst) begin
      mQ.delete();
      mOutValid  = 0;
      mOutWord   = '0;
      mUnder     = 0;
      mOver      = 0;
      modelKnown = 1;
    end else begin
      canPush = extV && (mQ.size() < DEPTH);
      if (inRd) begin
        if (mQ.size() > 0) void'(mQ.pop_front());
        else mUnder = 1;
      end
      if (canPush) mQ.push_back(extD);
      if (!mOutValid) begin
        if (outWr) begin
          mOutValid = 1;
          mOutWord  = outD;
        end
      end else if (ack && outWr) begin
        mOutWord = outD;
      end else if (ack) begin
        mOutValid = 0;
      end else if (outWr) begin
        mOver = 1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic doReset();
    cycle(1, 0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    Reset           = 1'b1;
    bus.InRead      = 1'b0;
    bus.OutputWrite = 1'b0;
    bus.OutData     = '0;
    bus.ExtInValid  = 1'b0;
    bus.ExtInData   = '0;
    bus.ExtOutAck   = 1'b0;
    @(negedge CLK);
    doReset();
    doReset();

    // reset state
    checkVal("rst_ready",  32'(bus.ExtInReady),  32'd1);
    checkVal("rst_empty",  32'(bus.InEmpty),     32'd1);
    checkVal("rst_indata", 32'(bus.InData),      32'd0);
    checkVal("rst_ovalid", 32'(bus.ExtOutValid), 32'd0);

    // two pushes, two pops
    cycle(0, 0, 0, '0, 1, 16'h0011, 0);
    checkVal("r039_first", 32'(bus.InData), 32'h0011);
    cycle(0, 0, 0, '0, 1, 16'h0022, 0);
    checkVal("r039_head", 32'(bus.InData), 32'h0011);
    cycle(0, 1, 0, '0, 0, '0, 0);
    checkVal("r039_pop1", 32'(bus.InData), 32'h0022);
    cycle(0, 1, 0, '0, 0, '0, 0);
    checkVal("r039_pop2", 32'(bus.InData), 32'h0000);
    checkVal("r039_empty", 32'(bus.InEmpty), 32'd1);
    checkVal("r039_noUf", 32'(bus.InUnderflow), 32'd0);

    // overfill: fifth word held off
    for (int i = 1; i <= 5; i++) cycle(0, 0, 0, '0, 1, DW'(i), 0);
    checkVal("r040_full", 32'(bus.ExtInReady), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      checkVal("r040_order", 32'(bus.InData), 32'(i));
      cycle(0, 1, 0, '0, 0, '0, 0);
    end
    checkVal("r040_drained", 32'(bus.InEmpty), 32'd1);

    // underflow is sticky
    cycle(0, 1, 0, '0, 0, '0, 0);
    checkVal("r041_uf", 32'(bus.InUnderflow), 32'd1);
    checkVal("r041_data", 32'(bus.InData), 32'd0);
    idle(); idle();
    checkVal("r041_sticky", 32'(bus.InUnderflow), 32'd1);
    // push + read while empty: push succeeds
    cycle(0, 1, 0, '0, 1, 16'h00A5, 0);
    checkVal("r026_head", 32'(bus.InData), 32'h00A5);
    // push + pop together with one queued: count stays at 1
    cycle(0, 1, 0, '0, 1, 16'h005A, 0);
    checkVal("r025_head", 32'(bus.InData), 32'h005A);
    doReset();

    // output path
    cycle(0, 0, 1, 16'hBEEF, 0, '0, 0);
    checkVal("r042_valid", 32'(bus.ExtOutValid), 32'd1);
    checkVal("r042_data", 32'(bus.ExtOutData), 32'hBEEF);
    cycle(0, 0, 1, 16'h1234, 0, '0, 0);
    checkVal("r043_hold", 32'(bus.ExtOutData), 32'hBEEF);
    checkVal("r043_ovf", 32'(bus.OutOverflow), 32'd1);
    cycle(0, 0, 1, 16'h1234, 0, '0, 1);
    checkVal("r043_swap", 32'(bus.ExtOutData), 32'h1234);
    checkVal("r043_valid", 32'(bus.ExtOutValid), 32'd1);
    cycle(0, 0, 0, '0, 0, '0, 1);
    checkVal("r042_ackd", 32'(bus.ExtOutValid), 32'd0);
    checkVal("r030_keep", 32'(bus.ExtOutData), 32'h1234);
    cycle(0, 0, 0, '0, 0, '0, 1);  // ack while idle is ignored
    checkVal("r033_idle", 32'(bus.ExtOutValid), 32'd0);

    // reset dominates activity
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, DW'(16'h0100 + i), 0);
    cycle(0, 0, 1, 16'hCAFE, 0, '0, 0);
    cycle(0, 1, 0, '0, 0, '0, 0);
    cycle(0, 1, 0, '0, 0, '0, 0);
    cycle(0, 1, 0, '0, 0, '0, 0);
    cycle(0, 1, 0, '0, 0, '0, 0);  // underflow
    cycle(0, 0, 1, 16'h7777, 0, '0, 0);  // overflow
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, DW'(16'h0200 + i), 0);
    cycle(1, 1, 1, 16'hDEAD, 1, 16'hFFFF, 1);
    checkVal("r044_empty", 32'(bus.InEmpty), 32'd1);
    checkVal("r044_ovalid", 32'(bus.ExtOutValid), 32'd0);
    checkVal("r044_odata", 32'(bus.ExtOutData), 32'd0);
    checkVal("r044_uf", 32'(bus.InUnderflow), 32'd0);
    checkVal("r044_of", 32'(bus.OutOverflow), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            DW'($urandom),
            $urandom_range(0, 1) == 1,
            DW'($urandom),
            $urandom_range(0, 1) == 1);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
